sar_adc_scan_ctrl: RTL and testbench
====================================

Name: sar_adc_scan_ctrl

Overview:
Parametrised successive-approximation ADC controller that sequences conversions across up to NCH analog channels through an external DAC and comparator. It replaces the fixed-width single-channel SAR logic. New capabilities: configurable resolution and settle time, a channel scan mask, single-shot or continuous mode, abort, and a valid/ready result port with back-pressure. It sits inside user_project_wrapper between the Wishbone/LA control registers and the io pads that drive the DAC and receive comp_in.

Parameters:
NBITS, 10, conversion resolution and DAC code width (2..16)
NCH, 4, number of analog channels (1..8)
SAMPLE_CYCLES, 4, cycles sample_o is held high per conversion (>=1)
SETTLE_CYCLES, 1, extra DAC settle cycles per bit before comp_in is sampled (>=0)
CHW, max(1,$clog2(NCH)), channel index width (derived)

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
start_i  in  1  start a scan; accepted only in IDLE with ch_mask_i != 0
cont_i  in  1  sampled with start; 1 = continuous scanning
abort_i  in  1  stop at once and return to IDLE
ch_mask_i  in  NCH  channels to scan; latched on start
comp_in  in  1  comparator output; 1 = Vin >= DAC
dac_code_o  out  NBITS  trial code to the DAC
sample_o  out  1  sample/hold switch enable
ch_sel_o  out  CHW  analog mux select
pad_oeb_o  out  NBITS+2  pad output enables for dac_code_o, sample_o and comp_in
busy_o  out  1  high in any state other than IDLE
result_o  out  NBITS  converted code
result_ch_o  out  CHW  channel of result_o
result_valid_o  out  1  result register full
result_ready_i  in  1  consumer accepts result_o

Behaviour:
- Reset values: every output is 0, except pad_oeb_o. pad_oeb_o is all-1 during reset. After reset it is 0 for the output bits and 1 for the comp_in bit. The mask register is cleared and the FSM is in IDLE.
- FSM states: IDLE, SAMPLE, CONVERT, WAIT, NEXT.
- IDLE:
  - start_i=1 and ch_mask_i!=0: latch mask and cont, set ch_sel_o to the lowest set bit, go to SAMPLE.
  - start_i with a zero mask is ignored.
  - start_i while busy is ignored.
- SAMPLE:
  - sample_o=1 and dac_code_o=0 for exactly SAMPLE_CYCLES cycles.
  - Then go to CONVERT with dac_code_o = 1<<(NBITS-1).
- CONVERT:
  - Each bit i, from MSB to LSB, occupies SETTLE_CYCLES+1 cycles.
  - comp_in is sampled on the last cycle of bit i. On that edge, bit i is cleared if comp_in=0 and bit i-1 is set.
  - After the LSB decision the final code is complete.
  - If the result register is empty, or result_ready_i=1 that cycle: load result_o and result_ch_o, set result_valid_o, go to NEXT.
  - Otherwise go to WAIT.
- WAIT: hold the final code. Load on the first cycle with result_ready_i=1 or an empty register, then go to NEXT.
- NEXT (1 cycle):
  - If a higher channel is set in the latched mask: select it and go to SAMPLE.
  - Else if cont=1: wrap to the lowest set channel and go to SAMPLE.
  - Else go to IDLE.
- Latency: result_valid_o rises SAMPLE_CYCLES + NBITS*(SETTLE_CYCLES+1) cycles after the start-accept edge. This is 24 cycles with the defaults.
- Handshake:
  - A transfer happens when result_valid_o & result_ready_i on a rising edge.
  - result_valid_o clears unless it is reloaded the same cycle.
  - result_o is stable while valid=1 and ready=0.
  - No result is ever dropped.
- abort_i:
  - Has priority over everything else. On the next edge: IDLE, dac_code_o=0, sample_o=0.
  - The in-progress conversion is discarded. The result register and result_valid_o are untouched.
- wb_rst_i mid-conversion: all state returns to reset values on the next edge.
- ch_mask_i changes after start have no effect until the next start.

Decomposition:
- Package sar_pkg holds:
  - the state enum;
  - a clog2-based CHW helper;
  - a function giving the lowest set bit of a mask at or above a given index.
- Sub-module sar_bit_engine holds the single-conversion successive-approximation register and the settle/bit counters.
  - Inputs: go, comp_in, kill.
  - Outputs: code, done.
  - Parameters: NBITS, SETTLE_CYCLES.
- The top level keeps the scan FSM, the channel pointer and the result register.

Test Plan:
- Defaults, mask=4'b0001, cont=0, comp_in modelled from Vin=0x2A5 against the DAC code:
  - result_o=0x2A5 and result_ch_o=0;
  - result_valid_o rises 24 cycles after start;
  - busy_o falls 1 cycle later.
- Edge codes: comp_in tied 1 gives result 0x3FF; comp_in tied 0 gives result 0x000. With SETTLE_CYCLES=0 the latency is 14.
- Mask=4'b1010, cont=1, ready held 1: results alternate on channels 1,3,1,3, each with its own modelled Vin. ch_sel_o tracks them.
- Mask=4'b0111, ready held 0 for 100 cycles:
  - the first result is held;
  - the FSM stalls in WAIT with the channel-1 code;
  - on ready, channels 1 and 2 deliver in order with no loss.
- abort_i in mid-CONVERT on the 5th bit: IDLE next cycle, dac_code_o=0, the prior valid result is retained, and a restart converts correctly.
- Ignored starts: start with mask=0 stays in IDLE; start while busy has no effect. wb_rst_i mid-SAMPLE returns all outputs to reset values and pad_oeb_o to all-1.

Source files
------------

// File: rtl/sar_adc_scan_ctrl_pkg.sv
// Shared types and helpers for the SAR ADC scan controller.
package sar_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_CONVERT,
    S_WAIT,
    S_NEXT
  } state_e;

  // Widest channel mask the helpers below understand.
  localparam int MAX_CH = 8;

  // Channel index width; a single channel still needs one select bit.
  function automatic int chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Lowest set bit of mask at or above index 'from'; -1 when none is set.
  function automatic int lowest_set_from(input logic [MAX_CH-1:0] mask, input int from);
    int r;
    r = -1;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from)) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/sar_adc_scan_ctrl_if.sv
// Result port of the scan controller: code + channel with valid/ready back-pressure.
interface sar_adc_scan_ctrl_if #(
  parameter int NBITS = 10,
  parameter int CHW   = 2
);
  logic [NBITS-1:0] result_o;
  logic [CHW-1:0]   result_ch_o;
  logic             result_valid_o;
  logic             result_ready_i;

  modport master (output result_o, output result_ch_o, output result_valid_o,
                  input  result_ready_i);
  modport slave  (input  result_o, input  result_ch_o, input  result_valid_o,
                  output result_ready_i);
endinterface

// File: rtl/sar_adc_scan_ctrl_bit_engine.sv
// Single successive-approximation conversion: trial register plus settle/bit counters.
module sar_bit_engine #(
  parameter int NBITS         = 10,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             go_i,
  input  logic             comp_in,
  input  logic             kill_i,
  output logic [NBITS-1:0] code_o,
  output logic             done_o
);

  localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int BW = $clog2(NBITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES);
  localparam logic [BW-1:0] BIT_MSB  = BW'(NBITS - 1);

  logic [NBITS-1:0] code_q, code_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             act_q, act_d;
  logic             decide;

  // Next-state: settle count per bit, then keep/clear the bit and trial the next one down.
  always_comb begin
    code_d = code_q;
    bit_d  = bit_q;
    cnt_d  = cnt_q;
    act_d  = act_q;
    decide = act_q && (cnt_q == CNT_LAST);
    done_o = decide && (bit_q == '0);
    if (kill_i) begin
      code_d = '0;
      bit_d  = '0;
      cnt_d  = '0;
      act_d  = 1'b0;
    end else if (go_i) begin
      code_d            = '0;
      code_d[NBITS-1]   = 1'b1;
      bit_d             = BIT_MSB;
      cnt_d             = '0;
      act_d             = 1'b1;
    end else if (act_q) begin
      if (decide) begin
        code_d[bit_q] = comp_in;
        if (bit_q != '0) begin
          code_d[bit_q - 1'b1] = 1'b1;
          bit_d                = bit_q - 1'b1;
          cnt_d                = '0;
        end else begin
          act_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State register; the final code is held after the LSB decision.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      code_q <= '0;
      bit_q  <= '0;
      cnt_q  <= '0;
      act_q  <= 1'b0;
    end else begin
      code_q <= code_d;
      bit_q  <= bit_d;
      cnt_q  <= cnt_d;
      act_q  <= act_d;
    end
  end

  assign code_o = code_q;

endmodule

// File: rtl/sar_adc_scan_ctrl.sv
// Multi-channel SAR ADC scan controller: scan FSM, channel pointer and result register.
module sar_adc_scan_ctrl
  import sar_pkg::*;
#(
  parameter int NBITS         = 10,
  parameter int NCH           = 4,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int CHW           = chw(NCH)
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               start_i,
  input  logic               cont_i,
  input  logic               abort_i,
  input  logic [NCH-1:0]     ch_mask_i,
  input  logic               comp_in,
  output logic [NBITS-1:0]   dac_code_o,
  output logic               sample_o,
  output logic [CHW-1:0]     ch_sel_o,
  output logic [NBITS+1:0]   pad_oeb_o,
  output logic               busy_o,
  sar_adc_scan_ctrl_if.master res_if
);

  localparam int SW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam logic [SW-1:0] SMP_LAST = SW'(SAMPLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [SW-1:0]    smp_q, smp_d;
  logic [NCH-1:0]   mask_q, mask_d;
  logic             cont_q, cont_d;
  logic [CHW-1:0]   ch_q, ch_d;
  logic [NBITS-1:0] res_q, res_d;
  logic [CHW-1:0]   res_ch_q, res_ch_d;
  logic             vld_q, vld_d;

  logic             eng_go, eng_kill, eng_done, load;
  logic [NBITS-1:0] eng_code, load_code;
  logic [MAX_CH-1:0] mask_ext;
  int               nxt;

  assign mask_ext = MAX_CH'(mask_q);

  sar_bit_engine #(
    .NBITS         (NBITS),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_engine (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .go_i    (eng_go),
    .comp_in (comp_in),
    .kill_i  (eng_kill),
    .code_o  (eng_code),
    .done_o  (eng_done)
  );

  // Scan sequencing, result loading and valid/ready bookkeeping; abort overrides all.
  always_comb begin
    state_d   = state_q;
    smp_d     = smp_q;
    mask_d    = mask_q;
    cont_d    = cont_q;
    ch_d      = ch_q;
    res_d     = res_q;
    res_ch_d  = res_ch_q;
    vld_d     = vld_q;
    eng_go    = 1'b0;
    eng_kill  = 1'b0;
    load      = 1'b0;
    load_code = eng_code;
    nxt       = -1;
    case (state_q)
      S_IDLE: begin
        if (start_i && (ch_mask_i != '0)) begin
          mask_d  = ch_mask_i;
          cont_d  = cont_i;
          ch_d    = CHW'(lowest_set_from(MAX_CH'(ch_mask_i), 0));
          smp_d   = '0;
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (smp_q == SMP_LAST) begin
          eng_go  = 1'b1;
          state_d = S_CONVERT;
        end else begin
          smp_d = smp_q + 1'b1;
        end
      end
      S_CONVERT: begin
        if (eng_done) begin
          // The LSB decision lands on this edge, so fold comp_in in directly.
          load_code = {eng_code[NBITS-1:1], comp_in};
          if (!vld_q || res_if.result_ready_i) begin
            load    = 1'b1;
            state_d = S_NEXT;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!vld_q || res_if.result_ready_i) begin
          load    = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        smp_d = '0;
        nxt   = lowest_set_from(mask_ext, int'(ch_q) + 1);
        if (nxt >= 0) begin
          ch_d    = CHW'(nxt);
          state_d = S_SAMPLE;
        end else if (cont_q) begin
          ch_d    = CHW'(lowest_set_from(mask_ext, 0));
          state_d = S_SAMPLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_i) begin
      state_d  = S_IDLE;
      eng_go   = 1'b0;
      eng_kill = 1'b1;
      load     = 1'b0;
    end
    if (vld_q && res_if.result_ready_i) vld_d = 1'b0;
    if (load) begin
      vld_d    = 1'b1;
      res_d    = load_code;
      res_ch_d = ch_q;
    end
  end

  // Controller state registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      smp_q    <= '0;
      mask_q   <= '0;
      cont_q   <= 1'b0;
      ch_q     <= '0;
      res_q    <= '0;
      res_ch_q <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      smp_q    <= smp_d;
      mask_q   <= mask_d;
      cont_q   <= cont_d;
      ch_q     <= ch_d;
      res_q    <= res_d;
      res_ch_q <= res_ch_d;
      vld_q    <= vld_d;
    end
  end

  assign dac_code_o = ((state_q == S_CONVERT) || (state_q == S_WAIT)) ? eng_code : '0;
  assign sample_o   = (state_q == S_SAMPLE);
  assign ch_sel_o   = ch_q;
  assign busy_o     = (state_q != S_IDLE);
  // Pads float (all disabled) while in reset; afterwards only comp_in stays an input.
  assign pad_oeb_o  = wb_rst_i ? '1 : {1'b1, {(NBITS + 1){1'b0}}};

  assign res_if.result_o       = res_q;
  assign res_if.result_ch_o    = res_ch_q;
  assign res_if.result_valid_o = vld_q;

endmodule

// File: tb/tb_sar_adc_scan_ctrl.sv
// Scoreboard bench for sar_adc_scan_ctrl with a comparator model driven by per-channel Vin.
module tb_sar_adc_scan_ctrl;

  localparam int NB = 10;
  localparam int NC = 4;

  typedef struct packed {
    logic [1:0]    ch;
    logic [NB-1:0] code;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          start = 1'b0, cont = 1'b0, abort_s = 1'b0;
  logic [NC-1:0] mask = '0;
  logic          comp;
  logic [NB-1:0] dac;
  logic          sample;
  logic [1:0]    chsel;
  logic [NB+1:0] pad;
  logic          busy;
  logic [NB-1:0] vin [NC];
  int            comp_mode = 0;

  // Second instance with zero settle time.
  logic          start2 = 1'b0;
  logic          comp2;
  logic [NB-1:0] dac2, vin2;
  logic          sample2, busy2;
  logic [1:0]    chsel2;
  logic [NB+1:0] pad2;

  sar_adc_scan_ctrl_if #(.NBITS(NB), .CHW(2)) rif ();
  sar_adc_scan_ctrl_if #(.NBITS(NB), .CHW(2)) rif2 ();

  assign comp  = (comp_mode == 1) ? 1'b1 : (comp_mode == 2) ? 1'b0 : (vin[chsel] >= dac);
  assign comp2 = (vin2 >= dac2);
  assign rif2.result_ready_i = 1'b1;

  sar_adc_scan_ctrl #(.NBITS(NB), .NCH(NC), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(1)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .cont_i(cont), .abort_i(abort_s),
    .ch_mask_i(mask), .comp_in(comp), .dac_code_o(dac), .sample_o(sample),
    .ch_sel_o(chsel), .pad_oeb_o(pad), .busy_o(busy), .res_if(rif));

  sar_adc_scan_ctrl #(.NBITS(NB), .NCH(NC), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(0)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start2), .cont_i(1'b0), .abort_i(1'b0),
    .ch_mask_i(4'b0001), .comp_in(comp2), .dac_code_o(dac2), .sample_o(sample2),
    .ch_sel_o(chsel2), .pad_oeb_o(pad2), .busy_o(busy2), .res_if(rif2));

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic prev_vld = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  // Monitor: pop the scoreboard on every accepted transfer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (rif.result_valid_o && !prev_vld && exp_q.size() > 0)
        chk("ch_sel_at_load", 32'(chsel), 32'(exp_q[0].ch));
      if (rif.result_valid_o && rif.result_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(rif.result_o), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("result_ch", 32'(rif.result_ch_o), 32'(e.ch));
          chk("result_code", 32'(rif.result_o), 32'(e.code));
        end
      end
    end
    prev_vld = rif.result_valid_o;
  end

  task automatic push_scan(input logic [NC-1:0] m);
    for (int i = 0; i < NC; i++)
      if (m[i]) exp_q.push_back('{ch: 2'(i), code: vin[i]});
  endtask

  task automatic start_scan(input logic [NC-1:0] m, input logic c);
    @(posedge clk); #1;
    start = 1'b1; mask = m; cont = c;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input bit rnd);
    int i;
    for (i = 0; i < budget; i++) begin
      if (!busy && exp_q.size() == 0 && !rif.result_valid_o) break;
      @(posedge clk); #1;
      if (rnd) rif.result_ready_i = 1'($urandom_range(0, 1));
    end
    if (rnd) rif.result_ready_i = 1'b1;
    chk("drain_in_time", 32'(i < budget), 32'd1);
  endtask

  task automatic measure(input bit second, output int lat);
    lat = 0;
    while (lat < 100 && !(second ? rif2.result_valid_o : rif.result_valid_o)) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [NB-1:0] a_code;
    rif.result_ready_i = 1'b1;
    for (int i = 0; i < NC; i++) vin[i] = '0;
    vin2 = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_pad_oeb", 32'(pad), 32'hFFF);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dac", 32'(dac), 0);
    chk("rst_sample", 32'(sample), 0);
    chk("rst_valid", 32'(rif.result_valid_o), 0);
    @(posedge clk); #1; rst = 1'b0; #1;
    chk("pad_oeb_run", 32'(pad), 32'h800);

    // Single channel, Vin = 0x2A5, latency and busy fall.
    vin[0] = 10'h2A5;
    push_scan(4'b0001);
    start_scan(4'b0001, 1'b0);
    measure(1'b0, lat);
    chk("latency_24", lat, 24);
    chk("busy_at_valid", 32'(busy), 1);
    @(posedge clk); #1;
    chk("busy_fall", 32'(busy), 0);
    wait_drain(100, 1'b0);

    // Edge codes.
    comp_mode = 1; exp_q.push_back('{ch: 2'd0, code: 10'h3FF});
    start_scan(4'b0001, 1'b0); wait_drain(100, 1'b0);
    comp_mode = 2; exp_q.push_back('{ch: 2'd0, code: 10'h000});
    start_scan(4'b0001, 1'b0); wait_drain(100, 1'b0);
    comp_mode = 0;

    // Random masks and Vin with random back-pressure.
    for (int t = 0; t < 4; t++) begin
      logic [NC-1:0] m;
      m = NC'($urandom_range(1, 15));
      for (int i = 0; i < NC; i++) vin[i] = NB'($urandom);
      push_scan(m);
      start_scan(m, 1'b0);
      wait_drain(800, 1'b1);
    end

    // Continuous scan on channels 1 and 3.
    for (int i = 0; i < NC; i++) vin[i] = NB'($urandom);
    repeat (2) push_scan(4'b1010);
    start_scan(4'b1010, 1'b1);
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) begin @(posedge clk); #1; end
    chk("cont_delivered", exp_q.size(), 0);
    abort_s = 1'b1; @(posedge clk); #1; abort_s = 1'b0;
    chk("cont_abort_idle", 32'(busy), 0);
    repeat (40) @(posedge clk); #1;
    chk("cont_no_extra", 32'(rif.result_valid_o), 0);

    // Back-pressure stall in WAIT.
    for (int i = 0; i < NC; i++) vin[i] = NB'($urandom);
    rif.result_ready_i = 1'b0;
    push_scan(4'b0111);
    start_scan(4'b0111, 1'b0);
    repeat (100) @(posedge clk); #1;
    chk("stall_valid", 32'(rif.result_valid_o), 1);
    chk("stall_held_ch", 32'(rif.result_ch_o), 0);
    chk("stall_held_code", 32'(rif.result_o), 32'(vin[0]));
    chk("stall_busy", 32'(busy), 1);
    chk("stall_ch_sel", 32'(chsel), 1);
    chk("stall_dac_code", 32'(dac), 32'(vin[1]));
    rif.result_ready_i = 1'b1;
    wait_drain(300, 1'b0);

    // Abort during the 5th bit keeps the prior result.
    rif.result_ready_i = 1'b0;
    vin[0] = NB'($urandom); a_code = vin[0];
    push_scan(4'b0001);
    start_scan(4'b0001, 1'b0);
    for (int i = 0; i < 60 && busy; i++) begin @(posedge clk); #1; end
    vin[0] = ~a_code;
    start_scan(4'b0001, 1'b0);
    repeat (12) @(posedge clk);
    #1; abort_s = 1'b1;
    @(posedge clk); #1; abort_s = 1'b0;
    chk("abort_idle", 32'(busy), 0);
    chk("abort_dac", 32'(dac), 0);
    chk("abort_sample", 32'(sample), 0);
    chk("abort_keep_valid", 32'(rif.result_valid_o), 1);
    chk("abort_keep_code", 32'(rif.result_o), 32'(a_code));
    vin[0] = NB'($urandom);
    push_scan(4'b0001);
    rif.result_ready_i = 1'b1;
    start_scan(4'b0001, 1'b0);
    wait_drain(200, 1'b0);

    // Ignored starts.
    start_scan(4'b0000, 1'b1);
    chk("zero_mask_idle", 32'(busy), 0);
    vin[0] = NB'($urandom);
    push_scan(4'b0001);
    start_scan(4'b0001, 1'b0);
    repeat (3) @(posedge clk);
    #1; start = 1'b1; mask = 4'hF; cont = 1'b1;
    @(posedge clk); #1; start = 1'b0; cont = 1'b0;
    wait_drain(200, 1'b0);
    chk("busy_start_ignored", 32'(busy), 0);

    // Reset mid-SAMPLE clears a held result and all outputs.
    rif.result_ready_i = 1'b0;
    vin[0] = NB'($urandom);
    start_scan(4'b0001, 1'b0);
    for (int i = 0; i < 60 && busy; i++) begin @(posedge clk); #1; end
    start_scan(4'b0001, 1'b0);
    @(posedge clk); #1;
    chk("pre_rst_sample", 32'(sample), 1);
    rst = 1'b1; #1;
    chk("rst_mid_pad", 32'(pad), 32'hFFF);
    @(posedge clk); #1;
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_sample", 32'(sample), 0);
    chk("rst_mid_valid", 32'(rif.result_valid_o), 0);
    chk("rst_mid_result", 32'(rif.result_o), 0);
    chk("rst_mid_chsel", 32'(chsel), 0);
    rst = 1'b0; rif.result_ready_i = 1'b1; #1;
    chk("rst_mid_pad_run", 32'(pad), 32'h800);

    // Zero settle time: latency 14.
    vin2 = NB'($urandom);
    @(posedge clk); #1; start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    measure(1'b1, lat);
    chk("latency_14", lat, 14);
    chk("settle0_code", 32'(rif2.result_o), 32'(vin2));

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
